stash_ctl: RTL and testbench
============================

# stash_ctl

Sequencing controller for the lap-sample `Stash` circular buffer in the stopwatch datapath. It turns debounced single-cycle button pulses (lap, browse, clear) into the Stash write/advance strobes, counts stored entries and tracks the browse index. It also drives the display-source select between the live time and the stored samples. It sits between the button front-end and the Stash/display mux.

## Interface
- `DEPTH`, 5: Stash depth in entries, 2..15.
- `TIMEOUT`, 500_000_000: idle cycles in BROWSE before auto-return to LIVE; must be ≥1.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; one clock; all state cleared immediately.
- `lap_btn` in 1: one-cycle pulse; store current live sample.
- `browse_btn` in 1: one-cycle pulse; enter or advance browse.
- `clear_btn` in 1: one-cycle pulse; discard all stored samples.
- `live_sample` in 8: current stopwatch value.
- `sample_in` out 8: registered data to Stash.
- `sample_in_valid` out 1: one-cycle Stash write strobe.
- `next_sample` out 1: one-cycle Stash read-pointer advance strobe.
- `stash_clear` out 1: one-cycle pulse; resets the Stash.
- `show_stash` out 1: 1 = display shows `sample_out`; 0 = display shows live time.
- `count` out 4: stored entries, 0..DEPTH, saturating.
- `index` out 4: current browse position, 0..count-1.
- `busy` out 1: high while in SKIP; all buttons are ignored.

## Operation
- States: LIVE, BROWSE, SKIP. Reset enters LIVE.
- Button priority in one cycle: clear > lap > browse. Lower-priority pulses in the same cycle are dropped.
- Any state except SKIP, `clear_btn`:
  - `stash_clear` pulses.
  - `count` = 0, `index` = 0.
  - State → LIVE.
- LIVE, `lap_btn`:
  - `sample_in` ← `live_sample`; `sample_in_valid` pulses.
  - `count` ← min(`count`+1, DEPTH).
- LIVE, `browse_btn`:
  - If `count` = 0: ignored.
  - Otherwise: → BROWSE, `index` = 0, no `next_sample` pulse.
- BROWSE, `lap_btn`: same write as in LIVE, then → LIVE.
- BROWSE, `browse_btn`:
  - If `index` < `count`-1: `next_sample` pulses, `index`+1.
  - If `index` = `count`-1 and `count` = DEPTH: `next_sample` pulses, `index` → 0 (Stash wraps naturally).
  - If `index` = `count`-1 and `count` < DEPTH: → SKIP.
- SKIP:
  - Issues `next_sample` on DEPTH-`count`+1 consecutive cycles so the Stash pointer lands back on entry 0.
  - Then → BROWSE with `index` = 0.
  - `busy` = 1 throughout; all buttons are ignored, including clear.
- Timeout: a counter runs in BROWSE and reloads on any accepted button. When it reaches TIMEOUT-1 → LIVE; no Stash strobes.
- `show_stash` = 1 in BROWSE and SKIP, else 0.
- `count` never exceeds DEPTH. Writes beyond DEPTH overwrite in the Stash; `count` stays DEPTH.

## Timing
- All outputs are registered; the response appears in the cycle after the edge that samples the button.
- `sample_in_valid`, `next_sample` and `stash_clear` are exactly one cycle wide per event.
- `sample_in` holds its last captured value between writes.
- `count` and `index` update on the same edge that asserts the corresponding strobe.
- SKIP length is exactly DEPTH-`count`+1 cycles of `next_sample` = 1. `busy` rises with the first pulse and falls with the last.
- Reset values:
  - `sample_in` = 0.
  - `sample_in_valid`, `next_sample`, `stash_clear`, `show_stash`, `busy` = 0.
  - `count` = 0, `index` = 0.
  - Timeout counter = 0.
- Reset asserted mid-SKIP or mid-BROWSE aborts at once: outputs return to reset values asynchronously. The first post-reset edge is in LIVE.

## Test plan
- Fill with DEPTH=5: lap ×3 with `live_sample` = 10, 20, 30. Required: three single-cycle `sample_in_valid` pulses carrying 10/20/30; `count` = 3; `show_stash` = 0.
- Saturation: lap ×7 (values 0..6). Required: 7 write strobes; `count` stops at 5.
- Browse wrap, not full: with `count` = 3, browse ×3. Required:
  - `index` goes 0, 1, 2 with one `next_sample` for each step after the first.
  - A 4th browse gives `busy` = 1 for 3 cycles with 3 consecutive `next_sample` pulses, then `index` = 0.
- Browse wrap, full: with `count` = 5, browse ×6. Required: 5 single `next_sample` pulses, `index` 0→4→0, no SKIP.
- Priority and timeout: clear and lap in the same cycle. Required: only `stash_clear` pulses; `count` = 0. Then, with TIMEOUT=8 and `count` = 2, browse once and idle 8 cycles. Required: `show_stash` drops to 0.
- Reset mid-SKIP: assert `reset` during the 2nd SKIP cycle. Required: `busy`, `next_sample`, `count` = 0 immediately; state LIVE after release.

Source files
------------

// File: rtl/stash_ctl.sv
// Lap-sample Stash sequencer: turns lap/browse/clear pulses into Stash write,
// advance and clear strobes, tracks stored count and browse index, selects display source.
module stash_ctl #(
   parameter int DEPTH   = 5,
   parameter int TIMEOUT = 500_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lap_btn,
   input  logic       browse_btn,
   input  logic       clear_btn,
   input  logic [7:0] live_sample,
   output logic [7:0] sample_in,
   output logic       sample_in_valid,
   output logic       next_sample,
   output logic       stash_clear,
   output logic       show_stash,
   output logic [3:0] count,
   output logic [3:0] index,
   output logic       busy
);
   localparam int              TW     = $clog2(TIMEOUT + 1);
   localparam logic [3:0]      DEPTH4 = 4'(DEPTH);
   localparam logic [TW-1:0]   TLAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {LIVE, BROWSE, SKIP} state_t;

   state_t        state;
   logic [3:0]    skip_left;
   logic [TW-1:0] idle_cnt;

   function automatic logic [3:0] sat_inc(input logic [3:0] c);
      return (c == DEPTH4) ? DEPTH4 : c + 4'd1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= LIVE;
         sample_in       <= 8'd0;
         sample_in_valid <= 1'b0;
         next_sample     <= 1'b0;
         stash_clear     <= 1'b0;
         show_stash      <= 1'b0;
         busy            <= 1'b0;
         count           <= 4'd0;
         index           <= 4'd0;
         skip_left       <= 4'd0;
         idle_cnt        <= '0;
      end else begin
         sample_in_valid <= 1'b0;
         next_sample     <= 1'b0;
         stash_clear     <= 1'b0;
         case (state)
            LIVE, BROWSE: begin
               // Any accepted button reloads the idle timer; only the idle path advances it.
               idle_cnt <= '0;
               if (clear_btn) begin
                  stash_clear <= 1'b1;
                  count       <= 4'd0;
                  index       <= 4'd0;
                  state       <= LIVE;
                  show_stash  <= 1'b0;
               end else if (lap_btn) begin
                  sample_in       <= live_sample;
                  sample_in_valid <= 1'b1;
                  count           <= sat_inc(count);
                  state           <= LIVE;
                  show_stash      <= 1'b0;
               end else if (browse_btn) begin
                  if (state == LIVE) begin
                     if (count != 4'd0) begin
                        state      <= BROWSE;
                        show_stash <= 1'b1;
                        index      <= 4'd0;
                     end
                  end else if (index < count - 4'd1) begin
                     next_sample <= 1'b1;
                     index       <= index + 4'd1;
                  end else if (count == DEPTH4) begin
                     next_sample <= 1'b1;
                     index       <= 4'd0;
                  end else begin
                     // Partially filled Stash: step its pointer past the empty slots back to entry 0.
                     state       <= SKIP;
                     busy        <= 1'b1;
                     next_sample <= 1'b1;
                     skip_left   <= DEPTH4 - count;
                  end
               end else if (state == BROWSE) begin
                  if (idle_cnt == TLAST) begin
                     state      <= LIVE;
                     show_stash <= 1'b0;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
            end
            SKIP: begin
               if (skip_left != 4'd0) begin
                  next_sample <= 1'b1;
                  skip_left   <= skip_left - 4'd1;
               end else begin
                  state    <= BROWSE;
                  busy     <= 1'b0;
                  index    <= 4'd0;
                  idle_cnt <= '0;
               end
            end
            default: state <= LIVE;
         endcase
      end
   end
endmodule

// File: tb/tb_stash_ctl.sv
// Randomized bench for stash_ctl with a cycle-level behavioural model and
// directed scenarios pinning fill, saturation, browse wrap, priority, timeout and reset.
module tb_stash_ctl;
   localparam int DEPTH   = 5;
   localparam int TIMEOUT = 8;
   localparam int LIV = 0, BRW = 1, SKP = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       lap_btn = 1'b0, browse_btn = 1'b0, clear_btn = 1'b0;
   logic [7:0] live_sample = 8'd0;
   logic [7:0] sample_in;
   logic       sample_in_valid, next_sample, stash_clear, show_stash, busy;
   logic [3:0] count, index;

   stash_ctl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .lap_btn(lap_btn), .browse_btn(browse_btn), .clear_btn(clear_btn),
      .live_sample(live_sample),
      .sample_in(sample_in), .sample_in_valid(sample_in_valid),
      .next_sample(next_sample), .stash_clear(stash_clear),
      .show_stash(show_stash), .count(count), .index(index), .busy(busy)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0, total_cnt = 0;
   int siv_cnt = 0, ns_cnt = 0, busy_cnt = 0;

   // model state: what the outputs must be after the most recent modelled edge
   int m_mode = LIV, m_count = 0, m_index = 0, m_si = 0;
   int m_siv = 0, m_ns = 0, m_clr = 0, m_pend = 0, m_stamp = 0, m_n = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      m_mode = LIV; m_count = 0; m_index = 0; m_si = 0;
      m_siv = 0; m_ns = 0; m_clr = 0; m_pend = 0; m_stamp = 0;
   endtask

   // One clock edge with the given button inputs.
   task automatic model_step(input logic l, input logic b, input logic c, input logic [7:0] v);
      m_n++;
      m_siv = 0; m_ns = 0; m_clr = 0;
      if (m_mode == SKP) begin
         if (m_pend > 0) begin m_ns = 1; m_pend--; end
         else begin m_mode = BRW; m_index = 0; m_stamp = m_n; end
      end else if (c) begin
         m_clr = 1; m_count = 0; m_index = 0; m_mode = LIV;
      end else if (l) begin
         m_si = v; m_siv = 1; m_mode = LIV;
         m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
      end else if (b) begin
         if (m_mode == LIV) begin
            if (m_count > 0) begin m_mode = BRW; m_index = 0; m_stamp = m_n; end
         end else begin
            m_stamp = m_n;
            if (m_index < m_count - 1) begin m_ns = 1; m_index++; end
            else if (m_count == DEPTH) begin m_ns = 1; m_index = 0; end
            else begin m_mode = SKP; m_pend = DEPTH - m_count + 1; m_ns = 1; m_pend--; end
         end
      end else if (m_mode == BRW && (m_n - m_stamp) == TIMEOUT) begin
         m_mode = LIV;
      end
   endtask

   task automatic compare();
      if (sample_in_valid) siv_cnt++;
      if (next_sample) ns_cnt++;
      if (busy) busy_cnt++;
      chk("sample_in", sample_in, m_si);
      chk("sample_in_valid", sample_in_valid, m_siv);
      chk("next_sample", next_sample, m_ns);
      chk("stash_clear", stash_clear, m_clr);
      chk("show_stash", show_stash, (m_mode != LIV) ? 1 : 0);
      chk("busy", busy, (m_mode == SKP) ? 1 : 0);
      chk("count", count, m_count);
      chk("index", index, m_index);
   endtask

   // Check outputs of the previous edge, then drive inputs for the next edge.
   task automatic cyc(input logic l, input logic b, input logic c, input logic [7:0] v);
      @(negedge clk);
      compare();
      lap_btn = l; browse_btn = b; clear_btn = c; live_sample = v;
      model_step(l, b, c, v);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 8'(m_n));
   endtask

   initial begin
      int s0, n0, b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_count", count, 0);
      chk("reset_show", show_stash, 0);
      chk("reset_strobes", {sample_in_valid, next_sample, stash_clear, busy}, 0);
      model_reset();
      #1 reset = 1'b0;

      // fill with three samples
      cyc(1, 0, 0, 8'd10); cyc(1, 0, 0, 8'd20); cyc(1, 0, 0, 8'd30); idle();
      chk("fill_count", count, 3);
      chk("fill_last_sample", sample_in, 30);
      chk("fill_writes", siv_cnt, 3);

      // browse a partially filled Stash, then wrap through SKIP
      n0 = ns_cnt;
      cyc(0, 1, 0, 0); idle(); chk("browse_idx0", index, 0);
      cyc(0, 1, 0, 0); idle(); chk("browse_idx1", index, 1);
      cyc(0, 1, 0, 0); idle(); chk("browse_idx2", index, 2);
      chk("browse_steps", ns_cnt - n0, 2);
      n0 = ns_cnt; b0 = busy_cnt;
      cyc(0, 1, 0, 0);
      repeat (5) idle();
      chk("skip_busy_cycles", busy_cnt - b0, 3);
      chk("skip_pulses", ns_cnt - n0, 3);
      chk("skip_idx", index, 0);
      chk("skip_show", show_stash, 1);

      // saturation
      cyc(0, 0, 1, 0);
      s0 = siv_cnt;
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 8'(i));
      idle();
      chk("sat_writes", siv_cnt - s0, 7);
      chk("sat_count", count, 5);
      chk("sat_sample", sample_in, 6);

      // full wrap without SKIP
      n0 = ns_cnt; b0 = busy_cnt;
      cyc(0, 1, 0, 0); idle();
      for (int j = 1; j <= 5; j++) begin
         cyc(0, 1, 0, 0); idle();
         if (j == 4) chk("full_idx4", index, 4);
      end
      chk("full_wrap_idx", index, 0);
      chk("full_pulses", ns_cnt - n0, 5);
      chk("full_no_skip", busy_cnt - b0, 0);

      // clear beats lap in the same cycle
      cyc(1, 0, 1, 8'd77); idle();
      chk("prio_clear", stash_clear, 1);
      chk("prio_no_write", sample_in_valid, 0);
      chk("prio_count", count, 0);

      // idle timeout back to LIVE
      cyc(1, 0, 0, 8'd1); cyc(1, 0, 0, 8'd2);
      cyc(0, 1, 0, 0);
      repeat (8) idle();
      chk("timeout_before", show_stash, 1);
      idle();
      chk("timeout_after", show_stash, 0);

      // reset during the second SKIP cycle (count 2 -> four SKIP pulses)
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
      idle();
      chk("midskip_busy_pre", busy, 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midskip_busy", busy, 0);
      chk("midskip_next", next_sample, 0);
      chk("midskip_count", count, 0);
      model_reset();
      @(negedge clk);
      #1 reset = 1'b0;
      cyc(0, 1, 0, 0); idle();
      chk("post_reset_live", show_stash, 0);
      cyc(1, 0, 0, 8'd55); idle();
      chk("post_reset_write", sample_in_valid, 1);
      chk("post_reset_count", count, 1);

      // randomized traffic
      repeat (3000) begin
         int r;
         r = $urandom_range(0, 99);
         cyc(r >= 3 && r < 20, r >= 20 && r < 52, r < 3, 8'($urandom));
      end
      idle();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
